// File: rtl/rtl8201_mii_mac_rx.sv
// ---------------------------------------------------------------------------
// rtl8201_mii_mac_rx
//
// Receive-side MAC for the RTL8201 MII PHY. It samples 4-bit nibbles while
// ETH_RX_DV is high, strips the 0x5 preamble and 0xD SFD, and assembles
// bytes low nibble first. Every post-SFD byte, the 4 FCS bytes included, is
// streamed to the user side. When DV falls, the block reports one
// end-of-frame status that covers CRC-32, length, RX_ER and nibble
// alignment.
//
// Ports
//   CLK          receive clock (ETH_RX_CLK); all logic uses the rising edge
//   RST          asynchronous, active-low reset
//   ETH_RX_DV    PHY receive data valid
//   ETH_RX_ER    PHY receive error
//   ETH_RX_DATA  PHY receive nibble
//   RECV_DATA    received byte, valid while RECV_VALID is high
//   RECV_VALID   one-cycle strobe per delivered byte
//   RECV_SOF     high with RECV_VALID on the first byte after the SFD
//   RECV_EOF     one-cycle end-of-frame strobe; status outputs are valid then
//   RECV_ERR     frame bad: CRC, RX_ER, odd nibble count, too short, too long
//   RECV_CRC_OK  CRC residue matched
//   RECV_LEN     bytes delivered in the frame, saturating at MAX_LEN
//   RECV_BUSY    high from the SFD until the RECV_EOF cycle inclusive
//
// There is no backpressure. The consumer must take one byte every 2 CLK.
// ---------------------------------------------------------------------------
module rtl8201_mii_mac_rx #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ETH_RX_DV,
  input  logic             ETH_RX_ER,
  input  logic [3:0]       ETH_RX_DATA,
  output logic [7:0]       RECV_DATA,
  output logic             RECV_VALID,
  output logic             RECV_SOF,
  output logic             RECV_EOF,
  output logic             RECV_ERR,
  output logic             RECV_CRC_OK,
  output logic [LEN_W-1:0] RECV_LEN,
  output logic             RECV_BUSY
);

  localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
  // Remainder left in the register after a good frame's FCS has been fed.
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0]       NIB_PRE     = 4'h5;
  localparam logic [3:0]       NIB_SFD     = 4'hD;
  localparam logic [LEN_W-1:0] MIN_LEN_C   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DROP
  } state_t;

  state_t state_reg, state_next;

  // dv_q_reg is the previous-cycle DV. It resets to 1, so a frame that is
  // already in flight when reset is released looks like "DV still high" and
  // is ignored until DV drops.
  logic             dv_q_reg;
  logic             phase_reg,    phase_next;     // 1: low nibble is held
  logic [3:0]       lo_nib_reg,   lo_nib_next;
  logic [31:0]      crc_reg,      crc_next;
  logic [LEN_W-1:0] count_reg,    count_next;     // saturates at MAX_LEN
  logic             over_reg,     over_next;      // saw a byte past MAX_LEN
  logic             rxer_reg,     rxer_next;      // RX_ER seen in DATA
  logic             sof_pend_reg, sof_pend_next;  // next delivered byte is first

  logic [7:0]       data_reg,     data_next;
  logic             valid_reg,    valid_next;
  logic             sof_reg,      sof_next;
  logic             eof_reg,      eof_next;
  logic             err_reg,      err_next;
  logic             crc_ok_reg,   crc_ok_next;
  logic [LEN_W-1:0] len_reg,      len_next;
  logic             busy_reg,     busy_next;

  logic             dv_rise;
  logic [7:0]       rx_byte;
  logic             crc_match;

  // Reflected CRC-32 over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_in[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  assign dv_rise   = ETH_RX_DV && !dv_q_reg;
  assign rx_byte   = {ETH_RX_DATA, lo_nib_reg};
  assign crc_match = (crc_reg == CRC_RESIDUE);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    lo_nib_next   = lo_nib_reg;
    crc_next      = crc_reg;
    count_next    = count_reg;
    over_next     = over_reg;
    rxer_next     = rxer_reg;
    sof_pend_next = sof_pend_reg;
    data_next     = data_reg;
    // Strobes and status are single-cycle pulses.
    valid_next    = 1'b0;
    sof_next      = 1'b0;
    eof_next      = 1'b0;
    err_next      = 1'b0;
    crc_ok_next   = 1'b0;
    len_next      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (dv_rise) begin
          if (ETH_RX_DATA == NIB_PRE) begin
            state_next = ST_PRE;
          end else begin
            state_next = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!ETH_RX_DV) begin
          // A carrier that ends inside the preamble is silently discarded.
          state_next = ST_IDLE;
        end else if (ETH_RX_ER) begin
          state_next = ST_DROP;
        end else if (ETH_RX_DATA == NIB_PRE) begin
          state_next = ST_PRE;
        end else if (ETH_RX_DATA == NIB_SFD) begin
          state_next    = ST_DATA;
          phase_next    = 1'b0;
          crc_next      = CRC_INIT;
          count_next    = '0;
          over_next     = 1'b0;
          rxer_next     = 1'b0;
          sof_pend_next = 1'b1;
        end else begin
          state_next = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!ETH_RX_DV) begin
          // End of frame. A held low nibble (phase_reg=1) means an odd
          // nibble count. That nibble is discarded and flags the frame.
          state_next  = ST_IDLE;
          eof_next    = 1'b1;
          crc_ok_next = crc_match;
          len_next    = count_reg;
          err_next    = !crc_match || rxer_reg || phase_reg ||
                        (count_reg < MIN_LEN_C) || over_reg;
        end else begin
          if (ETH_RX_ER) begin
            rxer_next = 1'b1;
          end
          phase_next = !phase_reg;
          if (!phase_reg) begin
            lo_nib_next = ETH_RX_DATA;
          end else begin
            // Bytes past MAX_LEN still go through the CRC. They are only
            // withheld from the user side and flagged as oversize.
            crc_next = crc32_byte(crc_reg, rx_byte);
            if (count_reg < MAX_LEN_C) begin
              count_next    = count_reg + LEN_ONE;
              valid_next    = 1'b1;
              data_next     = rx_byte;
              sof_next      = sof_pend_reg;
              sof_pend_next = 1'b0;
            end else begin
              over_next = 1'b1;
            end
          end
        end
      end

      ST_DROP: begin
        if (!ETH_RX_DV) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // BUSY stays high through the EOF cycle. That cycle is the one where
    // DATA is being left.
    busy_next = (state_reg == ST_DATA) || (state_next == ST_DATA);
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dv_q_reg     <= 1'b1;
      phase_reg    <= 1'b0;
      lo_nib_reg   <= '0;
      crc_reg      <= CRC_INIT;
      count_reg    <= '0;
      over_reg     <= 1'b0;
      rxer_reg     <= 1'b0;
      sof_pend_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      sof_reg      <= 1'b0;
      eof_reg      <= 1'b0;
      err_reg      <= 1'b0;
      crc_ok_reg   <= 1'b0;
      len_reg      <= '0;
      busy_reg     <= 1'b0;
    end else begin
      dv_q_reg     <= ETH_RX_DV;
      phase_reg    <= phase_next;
      lo_nib_reg   <= lo_nib_next;
      crc_reg      <= crc_next;
      count_reg    <= count_next;
      over_reg     <= over_next;
      rxer_reg     <= rxer_next;
      sof_pend_reg <= sof_pend_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      sof_reg      <= sof_next;
      eof_reg      <= eof_next;
      err_reg      <= err_next;
      crc_ok_reg   <= crc_ok_next;
      len_reg      <= len_next;
      busy_reg     <= busy_next;
    end
  end

  assign RECV_DATA   = data_reg;
  assign RECV_VALID  = valid_reg;
  assign RECV_SOF    = sof_reg;
  assign RECV_EOF    = eof_reg;
  assign RECV_ERR    = err_reg;
  assign RECV_CRC_OK = crc_ok_reg;
  assign RECV_LEN    = len_reg;
  assign RECV_BUSY   = busy_reg;

endmodule
